keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Scan controller for the 4x4 hexadecimal keypad interface. Drives rows one at a time, synchronises and debounces the column inputs, and produces a 4-bit key code together with the load enable for the enable-gated D flip-flop key register downstream. Sits between the keypad pins and the output encoder/register stage.

## Interface
- SCAN_DIV, 16: clocks per row dwell; scan tick period; must be >= 4
- DEBOUNCE_CYCLES, 4: consecutive stable scan ticks required for press and for release; must be >= 1
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- col_i  in  4  keypad columns, active-low (pulled up), asynchronous to clk
- row_o  out  4  row drive, one-hot active-low
- key_code  out  4  encoded key, held until the next capture
- key_load  out  1  one-cycle enable to the key register (the EN of the D flip-flops)
- key_valid  out  1  one-cycle pulse, coincident with key_load
- key_held  out  1  high while the captured key remains pressed

## Operation
- col_i passes through a 2-flop synchroniser; all decisions use the synchronised value col_s.
- Tick generator: divider counts 0..SCAN_DIV-1; tick = 1 on terminal count, then wraps to 0.
- Column decode: active column = lowest index with col_s[i]=0; "pressed" = any bit low.
- FSM states: SCAN, DEBOUNCE, CAPTURE, HOLD.
- SCAN: on tick, if pressed, latch row index and column pattern, clear debounce count, go DEBOUNCE with row frozen. Otherwise rotate row_o (1110 -> 1101 -> 1011 -> 0111 -> 1110).
- DEBOUNCE: on each tick, if col_s equals the latched pattern, increment the count; when the count reaches DEBOUNCE_CYCLES go CAPTURE. On mismatch, go SCAN and rotate to the next row on the same tick.
- CAPTURE: a single clock. key_code <= lookup(row, col); key_load = key_valid = 1; go HOLD.
- HOLD: row frozen, key_held = 1. Each tick with col_s all-high increments the release count; any tick with a key pressed clears it. At DEBOUNCE_CYCLES go SCAN and rotate the row. No new capture is possible until release completes.
- Key map rows 0-3: {1,2,3,A}, {4,5,6,B}, {7,8,9,C}, {E(*),0,F(#),D}.

## Timing
- Reset values: row_o=4'b1110, key_code=4'h0, key_load=0, key_valid=0, key_held=0, state SCAN, divider, debounce count and synchroniser all 0 / all-high (sync flops reset to 1).
- Reset asserted mid-operation returns immediately to the reset values. No pending pulse survives.
- Input-to-decision latency is 2 clk (synchroniser).
- Press latency: first pressed tick T0, then key_valid rises 1 clk after tick T0+DEBOUNCE_CYCLES.
- key_valid and key_load are high for exactly one clk per accepted press. key_code changes only in that same cycle.
- key_held rises the clk after CAPTURE and falls the clk after the final release tick.
- Divider free-runs in every state. A state change never restarts it.

## Configuration
- KEYPAD_MULTIKEY_REJECT_EN defined: a column pattern with more than one low bit counts as not pressed in SCAN and as a mismatch in DEBOUNCE. Simultaneous keys are ignored.
- Not defined: the lowest-index low column wins, and the pattern must stay identical through debounce.

## Structure
- Package keypad_pkg holds the state enum (SCAN, DEBOUNCE, CAPTURE, HOLD), the 16-entry key map constant and the row rotation reset constant 4'b1110.
- Sub-module: keypad_sync2, a 2-flop synchroniser with parameterised width and reset value 1.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CYCLES=3.

- Reset release with no key -> row_o walks 1110, 1101, 1011, 0111, 1110, changing every 4 clk. key_valid never asserts.
- Hold row1/col2 ("6") low, stable -> one key_valid pulse, key_code=4'h6, key_load coincident, key_held=1 until release plus 3 ticks.
- Bounce: row0/col0 low for 1 tick, high for 1 tick -> no key_valid; row_o resumes at 1101.
- Key held 200 clk -> exactly one key_valid. Release and press row3/col3 -> second pulse with key_code=4'hD.
- Row2 col0 and col1 both low -> with KEYPAD_MULTIKEY_REJECT_EN, no capture. Without it, key_code=4'h7.
- rst_n low during DEBOUNCE and again during HOLD -> all outputs return to reset values within the asynchronous reset, and no key_valid follows.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner: FSM state
// encoding, row-drive reset pattern, and the row/column to key-code map.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    CAPTURE,
    HOLD
  } state_t;

  // Row 0 driven low first; rotation walks the zero towards row 3.
  localparam logic [3:0] ROW_RST = 4'b1110;

  // Nibble {row,col} holds the key code.
  // Rows: {1,2,3,A}, {4,5,6,B}, {7,8,9,C}, {E(*),0,F(#),D}.
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [5:0] base;
    base = {row, col, 2'b00};
    return KEY_MAP[base +: 4];
  endfunction

  // True when more than one column line is pulled low.
  function automatic logic multi_low(input logic [3:0] col);
    logic [3:0] low;
    low = ~col;
    return (low & (low - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchroniser for the asynchronous keypad column lines.
// Flops reset to all-ones so an idle (pulled-up) keypad is seen at reset.
module keypad_sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p0;

  // Metastability chain: first stage may go metastable, second settles it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '1;
      q       <= '1;
    end else begin
      sync_p0 <= d;
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan controller: rotates the active-low row drive, debounces
// the synchronised columns, and emits a one-cycle key_load/key_valid with
// the encoded key. Optional build macro KEYPAD_MULTIKEY_REJECT_EN makes
// patterns with more than one low column count as "no key".
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_i,
  output logic [3:0] row_o,
  output logic [3:0] key_code,
  output logic       key_load,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       col_s;
  logic [DIV_W-1:0] div;
  logic             tick;
  state_t           state;
  logic [1:0]       row_idx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       lat_pat;
  logic [1:0]       lat_col;
  logic [1:0]       col_idx;
  logic             pressed;
  logic             press_ok;
  logic             match;

  keypad_sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (col_i),
    .q     (col_s)
  );

  // Free-running row dwell divider; never restarted by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign tick = (div == DIV_LAST);

  // Column decode: lowest low column wins; optional multi-key rejection.
  always_comb begin
    col_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s[i]) col_idx = 2'(i);
    end
    pressed = ~&col_s;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    press_ok = pressed & ~multi_low(col_s);
    match    = (col_s == lat_pat) & ~multi_low(col_s);
`else
    press_ok = pressed;
    match    = (col_s == lat_pat);
`endif
  end

  // Column pattern and index captured on the first pressed tick (data only).
  always_ff @(posedge clk) begin
    if (state == SCAN && tick && press_ok) begin
      lat_pat <= col_s;
      lat_col <= col_idx;
    end
  end

  // Scan/debounce/capture/hold sequencing with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      row_o     <= ROW_RST;
      row_idx   <= 2'd0;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_load  <= 1'b0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_load  <= 1'b0;
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (tick) begin
            if (press_ok) begin
              cnt   <= '0;
              state <= DEBOUNCE;
            end else begin
              row_o   <= {row_o[2:0], row_o[3]};
              row_idx <= row_idx + 2'd1;
            end
          end
        end
        DEBOUNCE: begin
          if (tick) begin
            if (match) begin
              if (cnt == CNT_LAST) begin
                // Code and strobes land together so the key register sees them in one cycle.
                state     <= CAPTURE;
                key_code  <= key_lookup(row_idx, lat_col);
                key_load  <= 1'b1;
                key_valid <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              state   <= SCAN;
              row_o   <= {row_o[2:0], row_o[3]};
              row_idx <= row_idx + 2'd1;
            end
          end
        end
        CAPTURE: begin
          key_held <= 1'b1;
          cnt      <= '0;
          state    <= HOLD;
        end
        HOLD: begin
          if (tick) begin
            if (&col_s) begin
              if (cnt == CNT_LAST) begin
                state    <= SCAN;
                key_held <= 1'b0;
                cnt      <= '0;
                row_o    <= {row_o[2:0], row_o[3]};
                row_idx  <= row_idx + 2'd1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              cnt <= '0;
            end
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 keypad matrix
// and a queue of expected key codes consumed on each key_valid pulse.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] col_i;
  logic [3:0] row_o;
  logic [3:0] key_code;
  logic       key_load;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;        // bit r*4+c = key at row r, column c pressed
  logic [3:0]  exp_q[$];
  int          n_assert;
  int          n_fail;
  int          valid_count;
  int          edges;
  logic [3:0]  last_code;
  logic        prev_valid;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_i     (col_i),
    .row_o     (row_o),
    .key_code  (key_code),
    .key_load  (key_load),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_o[r] && keys[r*4+c]) col_i[c] = 1'b0;
  end

  // Posedges since reset release; edge n is a scan tick when n % 4 == 0.
  always @(posedge clk) begin
    if (!rst_n) edges = 0;
    else        edges = edges + 1;
  end

  // Output monitor: pulse pairing, expected code, code stability, held follow-up.
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid || key_load) begin
        n_assert++;
        assert (key_load === key_valid) else begin
          n_fail++;
          $error("FAIL load_vs_valid observed load=%b valid=%b required equal", key_load, key_valid);
        end
      end
      if (key_valid) begin
        valid_count++;
        n_assert++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL spurious_valid observed code=%h required no pulse", key_code);
        end
        if (exp_q.size() != 0) begin
          logic [3:0] e;
          e = exp_q.pop_front();
          n_assert++;
          assert (key_code === e) else begin
            n_fail++;
            $error("FAIL sb_code observed=%h expected=%h", key_code, e);
          end
        end
        last_code = key_code;
      end else begin
        n_assert++;
        assert (key_code === last_code) else begin
          n_fail++;
          $error("FAIL code_stable observed=%h expected=%h", key_code, last_code);
        end
      end
      if (prev_valid) begin
        n_assert++;
        assert (key_held === 1'b1) else begin
          n_fail++;
          $error("FAIL held_after_valid observed=%b expected=1", key_held);
        end
      end
      prev_valid = key_valid;
    end else begin
      last_code  = 4'h0;
      prev_valid = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns just after the posedge where row_o switches to pat.
  task automatic wait_row(input logic [3:0] pat);
    logic left, found;
    left  = (row_o != pat);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(posedge clk); #1;
      if (row_o != pat) left = 1'b1;
      else if (left) found = 1'b1;
    end
    chk("wait_row", found, 1'b1);
  endtask

  // Press right after the row becomes active: pulse expected 16 edges later.
  task automatic press_and_check(input logic [3:0] rowpat, input logic [15:0] mask,
                                 input logic [3:0] code);
    wait_row(rowpat);
    keys = mask;
    exp_q.push_back(code);
    repeat (15) @(posedge clk);
    #1;
    chk("kv_early", key_valid, 1'b0);
    @(posedge clk); #1;
    chk("kv_rise", key_valid, 1'b1);
    chk("kl_rise", key_load, 1'b1);
    chk("code_at_load", key_code, code);
    chk("row_frozen", row_o, rowpat);
    @(posedge clk); #1;
    chk("kv_fall", key_valid, 1'b0);
    chk("held_rise", key_held, 1'b1);
  endtask

  // Release all keys in HOLD; key_held falls right after the third release tick.
  task automatic release_and_check(input logic [3:0] next_row);
    int m, t1, tf;
    m  = edges;
    keys = 16'h0;
    t1 = m + 3;
    while (t1 % 4 != 0) t1++;
    tf = t1 + 8;
    for (int i = 0; i < 40 && edges < tf - 1; i++) begin
      @(posedge clk); #1;
    end
    chk("held_before_release", key_held, 1'b1);
    @(posedge clk); #1;
    chk("held_fall", key_held, 1'b0);
    chk("row_after_release", row_o, next_row);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_row"}, row_o, 4'b1110);
    chk({tag, "_code"}, key_code, 4'h0);
    chk({tag, "_valid"}, key_valid, 1'b0);
    chk({tag, "_load"}, key_load, 1'b0);
    chk({tag, "_held"}, key_held, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] walk [5];
    logic [3:0] prev;
    int         base;
    walk = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101};
    n_assert = 0; n_fail = 0; valid_count = 0; edges = 0;
    last_code = 4'h0; prev_valid = 1'b0;
    keys  = 16'h0;
    rst_n = 1'b0;

    // Reset state, then idle row walk every 4 clk
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    prev = 4'b1110;
    for (int k = 0; k < 5; k++) begin
      repeat (3) @(posedge clk);
      #1;
      chk("walk_hold", row_o, prev);
      @(posedge clk); #1;
      chk("walk_step", row_o, walk[k]);
      prev = walk[k];
    end
    chk("idle_no_valid", valid_count, 0);

    // Key "6" held 200 clk: exactly one pulse, then release
    press_and_check(4'b1101, 16'h0040, 4'h6);
    base = valid_count;
    repeat (200) @(posedge clk);
    #1;
    chk("single_pulse", valid_count, base);
    chk("held_long", key_held, 1'b1);
    release_and_check(4'b1011);

    // Bounce on key "1": one tick low, then high -> rejected, scan resumes at row1
    base = valid_count;
    wait_row(4'b1110);
    keys = 16'h0001;
    repeat (4) @(posedge clk);
    #1;
    chk("bounce_frozen", row_o, 4'b1110);
    keys = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("bounce_still", row_o, 4'b1110);
    @(posedge clk); #1;
    chk("bounce_resume", row_o, 4'b1101);
    repeat (20) @(posedge clk);
    #1;
    chk("bounce_no_valid", valid_count, base);

    // Second key "D" after a release
    press_and_check(4'b0111, 16'h8000, 4'hD);
    release_and_check(4'b1110);

    // Row 2, columns 0 and 1 together
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    base = valid_count;
    wait_row(4'b1011);
    keys = 16'h0300;
    repeat (4) @(posedge clk);
    #1;
    chk("multi_rotates", row_o, 4'b0111);
    repeat (40) @(posedge clk);
    #1;
    chk("multi_no_valid", valid_count, base);
    keys = 16'h0000;
`else
    press_and_check(4'b1011, 16'h0300, 4'h7);
    release_and_check(4'b0111);
`endif

    // Reset during DEBOUNCE
    base = valid_count;
    wait_row(4'b1101);
    keys = 16'h0020;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_deb");
    keys = 16'h0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_deb_no_valid", valid_count, base);

    // Reset during HOLD on key "9"
    press_and_check(4'b1011, 16'h0400, 4'h9);
    base = valid_count;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_hold");
    keys = 16'h0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_hold_no_valid", valid_count, base);
    chk("rst_hold_idle_held", key_held, 1'b0);

    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
